sha256_msg_sequencer: RTL and testbench



---
 rtl/sha256_msg_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sequencer.sv
// SHA-256 message sequencer: packs a byte stream into 512-bit blocks, applies
// FIPS 180-4 padding, drives an external compression core one block at a time
// and returns the final digest over a valid/ready handshake.
// Optional build macro: SHA256_SEQ_DOUBLE_EN adds input dbl for SHA-256d.
`timescale 1ns/1ps
module sha256_msg_sequencer #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
`ifdef SHA256_SEQ_DOUBLE_EN
  input  logic         dbl,
`endif
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy,
  output logic         core_start,
  output logic         core_first,
  output logic [511:0] core_block,
  input  logic [255:0] core_hash,
  input  logic         core_ready
);

  typedef enum logic [2:0] {StAccept, StSend, StWait, StPad, StOut} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [511:0]       buf_q, buf_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               final_q, final_d;
  logic               pad_pend_q, pad_pend_d;
  logic               need_80_q, need_80_d;
  logic               wait_arm_q, wait_arm_d;
  logic               msg_open_q, msg_open_d;
  logic               in_ready_q, in_ready_d;
  logic [255:0]       digest_q, digest_d;
`ifdef SHA256_SEQ_DOUBLE_EN
  logic               dbl_q, dbl_d;
  logic               second_q, second_d;
`endif

  logic [LEN_W-1:0]   cnt_inc;
  logic [8:0]         cur_lo;
  logic [8:0]         nxt_lo;
  logic               accept;

  // Message bit length as a 64-bit big-endian field: {count, 3'b000}.
  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
    logic [63:0] r;
    r = '0;
    r[LEN_W+2:0] = {c, 3'b000};
    return r;
  endfunction

  assign cnt_inc = cnt_q + LEN_W'(1);
  // Bit offsets of byte idx and byte idx+1 inside the block (byte 0 at the top).
  assign cur_lo  = {6'd63 - idx_q, 3'b000};
  assign nxt_lo  = {6'd62 - idx_q, 3'b000};
  assign accept  = in_valid && in_ready_q;

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    final_d    = final_q;
    pad_pend_d = pad_pend_q;
    need_80_d  = need_80_q;
    wait_arm_d = wait_arm_q;
    msg_open_d = msg_open_q;
    digest_d   = digest_q;
`ifdef SHA256_SEQ_DOUBLE_EN
    dbl_d      = dbl_q;
    second_d   = second_q;
`endif

    unique case (state_q)
      StAccept: begin
        if (accept) begin
          buf_d[cur_lo +: 8] = in_data;
          cnt_d              = cnt_inc;
          msg_open_d         = 1'b1;
`ifdef SHA256_SEQ_DOUBLE_EN
          if (!msg_open_q) begin
            dbl_d = dbl;
          end
`endif
          if (!in_last) begin
            if (idx_q != 6'd63) begin
              idx_d = idx_q + 6'd1;
            end else begin
              final_d = 1'b0;
              state_d = StSend;
            end
          end else if (idx_q <= 6'd54) begin
            // Padding and length both fit in this block.
            buf_d[nxt_lo +: 8] = 8'h80;
            buf_d[63:0]        = bit_len(cnt_inc);
            final_d            = 1'b1;
            state_d            = StSend;
          end else if (idx_q != 6'd63) begin
            // 0x80 fits, length spills into an extra block.
            buf_d[nxt_lo +: 8] = 8'h80;
            pad_pend_d         = 1'b1;
            need_80_d          = 1'b0;
            state_d            = StSend;
          end else begin
            pad_pend_d = 1'b1;
            need_80_d  = 1'b1;
            state_d    = StSend;
          end
        end
      end

      StSend: begin
        first_d    = 1'b0;
        wait_arm_d = 1'b0;
        state_d    = StWait;
      end

      StWait: begin
        // core_ready may still show the previous block's status on the first cycle.
        if (!wait_arm_q) begin
          wait_arm_d = 1'b1;
        end else if (core_ready) begin
          if (final_q) begin
`ifdef SHA256_SEQ_DOUBLE_EN
            if (dbl_q && !second_q) begin
              // Re-hash the 32-byte inner digest as a fresh single-block message.
              buf_d    = {core_hash, 8'h80, 184'd0, 64'h100};
              first_d  = 1'b1;
              final_d  = 1'b1;
              second_d = 1'b1;
              state_d  = StSend;
            end else begin
              digest_d = core_hash;
              state_d  = StOut;
            end
`else
            digest_d = core_hash;
            state_d  = StOut;
`endif
          end else if (pad_pend_q) begin
            state_d = StPad;
          end else begin
            buf_d   = '0;
            idx_d   = '0;
            state_d = StAccept;
          end
        end
      end

      StPad: begin
        buf_d = '0;
        if (need_80_q) begin
          buf_d[511:504] = 8'h80;
        end
        buf_d[63:0] = bit_len(cnt_q);
        final_d     = 1'b1;
        pad_pend_d  = 1'b0;
        state_d     = StSend;
      end

      StOut: begin
        if (digest_ready) begin
          buf_d      = '0;
          cnt_d      = '0;
          idx_d      = '0;
          final_d    = 1'b0;
          pad_pend_d = 1'b0;
          need_80_d  = 1'b0;
          msg_open_d = 1'b0;
          first_d    = 1'b1;
`ifdef SHA256_SEQ_DOUBLE_EN
          dbl_d      = 1'b0;
          second_d   = 1'b0;
`endif
          state_d    = StAccept;
        end
      end

      default: begin
        state_d = StAccept;
      end
    endcase

    in_ready_d = (state_d == StAccept);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccept;
      idx_q      <= '0;
      buf_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      final_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      need_80_q  <= 1'b0;
      wait_arm_q <= 1'b0;
      msg_open_q <= 1'b0;
      in_ready_q <= 1'b0;
      digest_q   <= '0;
`ifdef SHA256_SEQ_DOUBLE_EN
      dbl_q      <= 1'b0;
      second_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      final_q    <= final_d;
      pad_pend_q <= pad_pend_d;
      need_80_q  <= need_80_d;
      wait_arm_q <= wait_arm_d;
      msg_open_q <= msg_open_d;
      in_ready_q <= in_ready_d;
      digest_q   <= digest_d;
`ifdef SHA256_SEQ_DOUBLE_EN
      dbl_q      <= dbl_d;
      second_q   <= second_d;
`endif
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready     = in_ready_q;
    digest_valid = (state_q == StOut);
    digest       = digest_q;
    core_start   = (state_q == StSend);
    core_first   = (state_q == StSend) && first_q;
    core_block   = buf_q;
    busy         = !((state_q == StAccept) && (idx_q == 6'd0) && !msg_open_q);
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Scoreboard bench for sha256_msg_sequencer with a behavioural compression core.
`timescale 1ns/1ps
module tb_sha256_msg_sequencer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [511:0] blk;
    logic         first;
  } blk_t;

  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;
  logic         core_start;
  logic         core_first;
  logic [511:0] core_block;
  logic [255:0] core_hash;
  logic         core_ready;
`ifdef SHA256_SEQ_DOUBLE_EN
  logic         dbl = 1'b0;
`endif

  int           total = 0;
  int           bad = 0;
  bit           hold_rdy = 1'b0;
  blk_t         exp_blk_q[$];
  logic [255:0] exp_dig_q[$];

  always #5 clk = ~clk;

  sha256_msg_sequencer #(.LEN_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
`ifdef SHA256_SEQ_DOUBLE_EN
    .dbl          (dbl),
`endif
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .busy         (busy),
    .core_start   (core_start),
    .core_first   (core_first),
    .core_block   (core_block),
    .core_hash    (core_hash),
    .core_ready   (core_ready)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain software SHA-256 compression of one block.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Pad a whole byte message, queue every expected block and return the hash.
  task automatic hash_bytes(input bq_t m, output logic [255:0] hout);
    bq_t          p;
    logic [63:0]  bl;
    logic [511:0] blk;
    blk_t         e;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8 * i +: 8]);
    hout = SHA_IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8 * j -: 8] = p[64 * bi + j];
      e.blk   = blk;
      e.first = (bi == 0);
      exp_blk_q.push_back(e);
      hout = sha_compress(hout, blk);
    end
  endtask

  task automatic model_msg(input bq_t m, input bit dbl_en, input bit use_known,
                           input logic [255:0] known);
    logic [255:0] h, h2;
    bq_t          d;
    hash_bytes(m, h);
    if (dbl_en) begin
      for (int i = 0; i < 32; i++) d.push_back(h[255 - 8 * i -: 8]);
      hash_bytes(d, h2);
      h = h2;
    end
    exp_dig_q.push_back(use_known ? known : h);
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last byte is taken.
  task automatic send_bytes(input bq_t m, input bit last_at_end, input bit gaps);
    int n;
    bit acc;
    for (int i = 0; i < m.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = last_at_end && (i == m.size() - 1);
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 5000);
      if (!acc) begin
        fail_now("byte accept timeout");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_dig_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_dig_q.size() != 0) begin
      fail_now("digest timeout");
      exp_dig_q.delete();
      exp_blk_q.delete();
    end
  endtask

  // Behavioural compression core with a random per-block latency.
  logic [255:0] core_pend;
  int           core_cnt;
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b1;
      core_cnt   <= 0;
      core_hash  <= '0;
      core_pend  <= '0;
    end else begin
      if (core_cnt == 1) begin
        core_hash  <= core_pend;
        core_ready <= 1'b1;
      end
      if (core_cnt != 0) core_cnt <= core_cnt - 1;
      if (core_start) begin
        core_pend  <= sha_compress(core_first ? SHA_IV : core_hash, core_block);
        core_cnt   <= int'($urandom_range(10, 30));
        core_ready <= 1'b0;
      end
    end
  end

  // Consumer: random backpressure unless held off.
  initial begin
    forever begin
      @(posedge clk); #1;
      digest_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks every core launch and every digest handshake against the scoreboard.
  logic         stall_prev;
  logic [255:0] stall_dig;
  logic         prev_start;
  blk_t         eb;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk_bit("digest_valid held", digest_valid, 1'b1);
        chk_vec("digest stable", 512'(digest), 512'(stall_dig));
      end
      if (digest_valid) begin
        chk_bit("in_ready in OUT", in_ready, 1'b0);
        if (digest_ready) begin
          if (exp_dig_q.size() == 0) fail_now("unexpected digest");
          else chk_vec("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
        end
      end
      stall_prev <= digest_valid && !digest_ready;
      stall_dig  <= digest;
      if (core_start) begin
        chk_bit("core_start back-to-back", prev_start, 1'b0);
        if (exp_blk_q.size() == 0) begin
          fail_now("unexpected core_start");
        end else begin
          eb = exp_blk_q.pop_front();
          chk_vec("core_block", core_block, eb.blk);
          chk_bit("core_first", core_first, eb.first);
        end
      end
      prev_start <= core_start;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    bq_t part;
    int  n;
    bit  dsel;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("reset in_ready", in_ready, 1'b0);
    chk_bit("reset digest_valid", digest_valid, 1'b0);
    chk_vec("reset digest", 512'(digest), 512'd0);
    chk_bit("reset core_start", core_start, 1'b0);
    chk_bit("reset core_first", core_first, 1'b0);
    chk_bit("reset busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("in_ready after reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Known-answer vectors.
    model_msg(str2q("abc"), 1'b0, 1'b1,
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    send_bytes(str2q("abc"), 1'b1, 1'b0);
    wait_idle();
    m = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    model_msg(m, 1'b0, 1'b1,
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    send_bytes(m, 1'b1, 1'b0);
    wait_idle();

    // Full 64-byte block: padding needs a block that starts with 0x80.
    m = rand_msg(64);
    model_msg(m, 1'b0, 1'b0, '0);
    send_bytes(m, 1'b1, 1'b1);
    wait_idle();

    // 55 bytes with gappy input and the consumer stalled for 20 cycles.
    hold_rdy = 1'b1;
    m = rand_msg(55);
    model_msg(m, 1'b0, 1'b0, '0);
    send_bytes(m, 1'b1, 1'b1);
    n = 0;
    while (!digest_valid && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!digest_valid) fail_now("digest_valid never rose");
    repeat (20) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    hold_rdy = 1'b0;
    wait_idle();

    // Abort a two-block message while the core works on block 0.
    m = rand_msg(100);
    model_msg(m, 1'b0, 1'b0, '0);
    part = m[0:63];
    send_bytes(part, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("busy mid message", busy, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_blk_q.delete();
    exp_dig_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk_bit("busy after abort", busy, 1'b0);
    @(posedge clk); #1;
    model_msg(str2q("abc"), 1'b0, 1'b1,
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    send_bytes(str2q("abc"), 1'b1, 1'b1);
    wait_idle();

`ifdef SHA256_SEQ_DOUBLE_EN
    dbl = 1'b1;
    model_msg(str2q("abc"), 1'b1, 1'b1,
      256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358);
    send_bytes(str2q("abc"), 1'b1, 1'b0);
    wait_idle();
    dbl = 1'b0;
`endif

    // Random lengths, sent back to back.
    for (int k = 0; k < 8; k++) begin
      m    = rand_msg(int'($urandom_range(1, 150)));
      dsel = 1'b0;
`ifdef SHA256_SEQ_DOUBLE_EN
      dsel = 1'($urandom);
      dbl  = dsel;
`endif
      model_msg(m, dsel, 1'b0, '0);
      send_bytes(m, 1'b1, 1'b1);
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
